id_ex_stall_register: RTL

//  ID/EX pipeline register for the stalling (no-forwarding) 5-stage core. Captures register-file read data,

---
 rtl/id_ex_stall_register_pkg.sv | 27 ++
 rtl/id_ex_stall_register_hazard_detect.sv | 40 ++++
 rtl/id_ex_stall_register.sv | 126 ++++++++++++
 3 files changed

// File: rtl/id_ex_stall_register_pkg.sv
// Shared definitions for the ID/EX stall register: control bundle layout,
// stall FSM encoding and the hardwired-zero register address.
package id_ex_stall_register_pkg;

    localparam int unsigned CTRL_W       = 9;

    // Control bundle bit positions
    localparam int unsigned REG_WRITE_B  = 0;
    localparam int unsigned MEM_READ_B   = 1;
    localparam int unsigned MEM_WRITE_B  = 2;
    localparam int unsigned ALU_SRC_B    = 3;
    localparam int unsigned MEM_TO_REG_B = 4;
    localparam int unsigned ALU_OP_LSB   = 5;
    localparam int unsigned ALU_OP_W     = 4;

    localparam int unsigned ZERO_REG     = 0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_t;

    function automatic logic [ALU_OP_W-1:0] ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
        return ctrl[ALU_OP_LSB +: ALU_OP_W];
    endfunction

endpackage

// File: rtl/id_ex_stall_register_hazard_detect.sv
// Combinational RAW hazard detection of the ID sources against in-flight writers.
// Build option: ID_WB_BYPASS_EN removes the WB stage from the comparison.
module hazard_detect
    import id_ex_stall_register_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              id_valid,
    input  logic              flush,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_write,
    input  logic [ADDR_W-1:0] ex_dest,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_dest,
    output logic              hazard
);

    function automatic logic match(input logic [ADDR_W-1:0] d, input logic w);
        return w && (d != ADDR_W'(ZERO_REG)) &&
               ((d == id_rs) || (id_uses_rt && (d == id_rt)));
    endfunction

    logic wb_match;

`ifdef ID_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = wb_reg_write ^ (^wb_dest);
    assign wb_match  = 1'b0;
`else
    assign wb_match  = match(wb_dest, wb_reg_write);
`endif

    assign hazard = id_valid && !flush &&
                    (match(ex_dest, ex_write) || match(mem_dest, mem_reg_write) || wb_match);

endmodule

// File: rtl/id_ex_stall_register.sv
// ID/EX pipeline register with RAW-hazard stall, bubble injection and stall statistics.
// Build option: ID_WB_BYPASS_EN forwards the WB write data into the captured operands.
module id_ex_stall_register
    import id_ex_stall_register_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTRL_W = id_ex_stall_register_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd_dest,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              hold_pc,
    output logic              hold_if_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_dest,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    logic         hazard_raw;
    logic         stall;
    logic [DATA_W-1:0] rs_sel;
    logic [DATA_W-1:0] rt_sel;
    stall_state_t state, state_next;

    hazard_detect #(
        .ADDR_W (ADDR_W)
    ) u_hazard_detect (
        .id_valid      (id_valid),
        .flush         (flush),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_write      (ex_valid && ex_ctrl[REG_WRITE_B]),
        .ex_dest       (ex_dest),
        .mem_reg_write (mem_reg_write),
        .mem_dest      (mem_dest),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .hazard        (hazard_raw)
    );

    // Reset also drops the holds so the front end is released immediately.
    assign stall      = hazard_raw && rst;
    assign hold_pc    = stall;
    assign hold_if_id = stall;

`ifdef ID_WB_BYPASS_EN
    always_comb begin
        rs_sel = id_rs_data;
        rt_sel = id_rt_data;
        if (wb_reg_write && (wb_dest != ADDR_W'(ZERO_REG))) begin
            if (wb_dest == id_rs) rs_sel = wb_data;
            if (wb_dest == id_rt) rt_sel = wb_data;
        end
    end
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign rs_sel = id_rs_data;
    assign rt_sel = id_rt_data;
`endif

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (stall)  state_next = STALL;
            STALL:   if (!stall) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            stall_count <= '0;
        end else begin
            state <= state_next;
            if ((state_next == STALL) && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Bubbles clear only valid/ctrl/dest; operand registers keep their old contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid   <= 1'b0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_dest    <= '0;
            ex_ctrl    <= '0;
        end else if (flush || stall) begin
            ex_valid   <= 1'b0;
            ex_dest    <= '0;
            ex_ctrl    <= '0;
        end else begin
            ex_valid   <= id_valid;
            ex_rs_data <= rs_sel;
            ex_rt_data <= rt_sel;
            ex_imm     <= id_imm;
            ex_dest    <= id_rd_dest;
            ex_ctrl    <= id_ctrl;
        end
    end

endmodule
